imm_decode_pipe: RTL and testbench
==================================

# imm_decode_pipe

Registered, parametrised immediate decoder for the RISC-V datapath. It extracts and sign-extends the immediate for every RV32I/RV64I base format: I, S, B, U, J, and shift-amount. It also classifies the format and flags unsupported opcodes. It sits between fetch and execute as one pipeline stage, with a valid/ready handshake and a 2-entry skid buffer so that `in_ready` is driven from a register.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64. Sets the immediate width and the shamt width (5 bits when 32, 6 bits when 64).
- `TAG_W`, 8, width of the sideband tag carried alongside each instruction (PC index, ROB id, and similar).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; discards all buffered beats.
- `in_valid`  in  1  an upstream instruction is presented.
- `in_ready`  out  1  the stage can accept a beat.
- `in_instr`  in  32  instruction word.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  a decoded beat is presented.
- `out_ready`  in  1  downstream accepts the beat.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format code: 0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- `out_illegal`  out  1  opcode is not in the supported set.
- `out_instr`  out  32  instruction word, passed through.
- `out_tag`  out  TAG_W  tag, passed through.

## Operation
Decode is combinational on the incoming `in_instr`. Results are captured into the buffer, and all outputs come from registers.

Decode rules, keyed on `opcode = instr[6:0]`:
- I format for 0000011 (load), 1100111 (JALR), 1110011 (system), 0001111 (fence), and for 0010011/0011011 (OP-IMM and OP-IMM-32) when funct3 is not 001 or 101. The immediate is `instr[31:20]` sign-extended to XLEN.
- SHAMT format for 0010011 with funct3 of 001 or 101. The immediate is the zero-extended shamt: `instr[24:20]` when XLEN=32, `instr[25:20]` when XLEN=64. For 0011011, the shamt is always `instr[24:20]`.
- S format for 0100011: `{instr[31:25], instr[11:7]}`, sign-extended.
- B format for 1100011: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`, sign-extended.
- U format for 0110111 and 0010111: `{instr[31:12], 12'b0}`. When XLEN=64, this value is sign-extended from bit 31.
- J format for 1101111: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`, sign-extended.
- NONE format for 0110011 and 0111011 (R-type): the immediate is 0 and `out_illegal` is 0.
- Any other opcode: the immediate is 0, the format is NONE, and `out_illegal` is 1.
- When XLEN=32, the opcodes 0011011 and 0111011 are illegal.

Buffer:
- The buffer has two entries, `main` and `skid`, each holding an occupancy bit and a payload.
- The outputs always reflect `main`.
- `in_ready` equals the registered value of `!skid_valid`.
- A beat is accepted when `in_valid && in_ready`. It is transferred downstream when `out_valid && out_ready`.
- When `main` is empty or is transferring, it loads `skid` if `skid` is occupied, otherwise the accepted beat. Otherwise, an accepted beat goes into `skid`.
- Beats leave in the same order they were accepted; no beat is duplicated or dropped except by `flush`.
- A simultaneous accept and transfer with `skid` empty keeps `main` full with the new beat, giving a throughput of 1 per cycle.

Flush:
- On the edge where `flush` is 1, both occupancy bits clear and `in_ready` is 1 on the next cycle.
- A beat offered in the flush cycle is dropped. A transfer in the flush cycle still completes.

## Timing
- Reset values are `out_valid`=0, `in_ready`=1, and `out_imm`, `out_fmt`, `out_illegal`, `out_instr`, and `out_tag` all 0. Both entries are empty.
- A reset asserted mid-operation discards all beats immediately, with no dependence on the clock.
- Latency is 1 cycle: a beat accepted at edge N is visible with `out_valid`=1 after edge N.
- Under backpressure (`out_ready`=0 with `main` full), the first further accept fills `skid`, and `in_ready` falls after that same edge. Upstream may therefore drive one beat while `in_ready` is still 1, and that beat is never lost.
- Once `out_ready` rises, `skid` moves to `main` on the next edge, and `in_ready` returns to 1 after that same edge.
- `out_*` payload stays stable while `out_valid`=1 and `out_ready`=0.
- There are no combinational paths from the `out_ready` input to `in_ready`, or from any `in_*` input to any `out_*` output.

## Test plan
- Single beats with `out_ready`=1, XLEN=32, covering one encoding per format:
  - 0xFFC12083 gives imm 0xFFFFFFFC, fmt 1.
  - 0xFE112E23 gives imm 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 gives imm 0xFFFFFFF8, fmt 3.
  - 0x123450B7 gives imm 0x12345000, fmt 4.
  - 0x001000EF gives imm 0x00000800, fmt 5.
  - 0x40515093 (`srai`) gives imm 0x00000005, fmt 6.
  - Each appears exactly 1 cycle after it is accepted.
- Illegal and R-type handling:
  - 0x0000007F gives illegal=1, imm 0, fmt 0.
  - 0x002081B3 (`add`) gives illegal=0, imm 0, fmt 0.
  - With XLEN=32, 0x0000001B gives illegal=1. With XLEN=64, the same word gives fmt 1.
- XLEN=64 extension:
  - 0x800000B7 gives imm 0xFFFFFFFF80000000.
  - 0x03F11093 (`slli` with shamt 63) gives imm 63, fmt 6.
- Backpressure: hold `out_ready`=0 and stream tags 1, 2, 3, 4.
  - `in_ready` falls after tag 2 is accepted. Tags 3 and 4 wait upstream, and the `out_*` outputs stay stable.
  - Raising `out_ready` yields tags 1, 2, 3, 4 in order with no gaps or duplicates.
- Flush with both entries full while `in_valid`=1 presents tag 9:
  - The next cycle shows `out_valid`=0 and `in_ready`=1, and tag 9 is never output.
- Reset asserted asynchronously between edges with both entries full:
  - `out_valid` goes to 0 and `in_ready` to 1 immediately, and every output is 0.
- Random valid/ready stress for 10k beats against a reference model:
  - Order and payload match exactly, and no more than 2 beats are ever in flight.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// RISC-V immediate decoder as one pipeline stage: decodes in_instr combinationally,
// then buffers results in a 2-entry main/skid buffer so in_ready comes from a register.
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } beat_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam bit IS_RV64 = (XLEN == 64);

    // Every format is first built as a 32-bit signed value, then widened to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    beat_t           dec;

    always_comb begin
        opcode   = in_instr[6:0];
        funct3   = in_instr[14:12];
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        imm_i    = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        // NOTE: full default before the case so no path leaves a field unassigned (no latches).
        dec       = '0;
        dec.fmt   = FMT_NONE;
        dec.instr = in_instr;
        dec.tag   = in_tag;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = IS_RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
            end
            OPC_OP_IMM32: begin
                if (!IS_RV64) begin
                    dec.illegal = 1'b1;
                end else if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = XLEN'(in_instr[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
            end
            OPC_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0});
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = sext32({in_instr[31:12], 12'b0});
            end
            OPC_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0});
            end
            OPC_OP:   dec.illegal = 1'b0;
            OPC_OP32: dec.illegal = !IS_RV64;
            default:  dec.illegal = 1'b1;
        endcase
    end

    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  accept;
    logic  xfer;
    logic  main_free;

    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = main_valid_q && out_ready;
    assign main_free = !main_valid_q || xfer;

    // Main refills from skid first so beats leave in acceptance order.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: payload registers are reset too, so every out_* reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates from pre-edge values.
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_instr   = main_q.instr;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed and random bench for imm_decode_pipe; an XLEN=32 and an XLEN=64 instance
// share one stimulus stream and a queue-based scoreboard tracks handshakes.
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    logic        r32, v32, ill32;
    logic [31:0] imm32, oi32;
    logic [2:0]  fmt32;
    logic [7:0]  ot32;

    logic        r64, v64, ill64;
    logic [63:0] imm64;
    logic [31:0] oi64;
    logic [2:0]  fmt64;
    logic [7:0]  ot64;

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32), .TAG_W(8)) u32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_instr(oi32), .out_tag(ot32)
    );

    imm_decode_pipe #(.XLEN(64), .TAG_W(8)) u64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_instr(oi64), .out_tag(ot64)
    );

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] instr;
        logic [31:0] imm;
        bit          chk_imm;
    } item_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] i32;
        logic [2:0]  f32;
        logic        l32;
        logic [63:0] i64;
        logic [2:0]  f64;
        logic        l64;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    item_t       exp_q[$];
    logic [7:0]  out_log[$];
    logic [31:0] stim_imm;
    bit          stim_chk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard the handshakes of the coming edge, then advance to 1 ns after it.
    task automatic tick();
        item_t it;
        if (v32 && out_ready) begin
            out_log.push_back(ot32);
            check("sb_nonempty", (exp_q.size() > 0) ? 64'd1 : 64'd0, 64'd1);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                check("sb_payload", {ot32, oi32}, {it.tag, it.instr});
                if (it.chk_imm) check("sb_imm", imm32, it.imm);
            end
        end
        if (in_valid && r32 && !flush) begin
            it.tag     = in_tag;
            it.instr   = in_instr;
            it.imm     = stim_imm;
            it.chk_imm = stim_chk;
            exp_q.push_back(it);
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [7:0] tg);
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tg;
        tick();
    endtask

    vec_t vt[14];

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        in_tag    = '0;
        stim_imm  = '0;
        stim_chk  = 1'b0;

        vt[0]  = '{32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0};
        vt[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
        vt[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0};
        vt[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h00000000_12345000, 3'd4, 1'b0};
        vt[4]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h00000000_00000800, 3'd5, 1'b0};
        vt[5]  = '{32'h40515093, 32'h00000005, 3'd6, 1'b0, 64'h00000000_00000005, 3'd6, 1'b0};
        vt[6]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h00000000_00000000, 3'd0, 1'b1};
        vt[7]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h00000000_00000000, 3'd0, 1'b0};
        vt[8]  = '{32'h0000001B, 32'h00000000, 3'd0, 1'b1, 64'h00000000_00000000, 3'd1, 1'b0};
        vt[9]  = '{32'h03F11093, 32'h0000001F, 3'd6, 1'b0, 64'h00000000_0000003F, 3'd6, 1'b0};
        vt[10] = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
        vt[11] = '{32'h03F0909B, 32'h00000000, 3'd0, 1'b1, 64'h00000000_0000001F, 3'd6, 1'b0};
        vt[12] = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h00000000_00000000, 3'd0, 1'b0};
        vt[13] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", v32, 1'b0);
        check("rst_in_ready", r32, 1'b1);
        check("rst_imm", imm32, 0);
        check("rst_fmt", fmt32, 0);
        check("rst_illegal", ill32, 0);
        check("rst_instr", oi32, 0);
        check("rst_tag", ot32, 0);
        check("rst_out_valid64", v64, 1'b0);
        check("rst_imm64", imm64, 0);
        reset = 1'b0;

        // One beat per format, back to back; each is checked right after its accepting edge
        for (int i = 0; i < 14; i++) begin
            offer(vt[i].ins, 8'(i + 16));
            check($sformatf("dec%0d_valid", i), v32, 1'b1);
            check($sformatf("dec%0d_imm32", i), imm32, vt[i].i32);
            check($sformatf("dec%0d_fmt32", i), fmt32, vt[i].f32);
            check($sformatf("dec%0d_ill32", i), ill32, vt[i].l32);
            check($sformatf("dec%0d_imm64", i), imm64, vt[i].i64);
            check($sformatf("dec%0d_fmt64", i), fmt64, vt[i].f64);
            check($sformatf("dec%0d_ill64", i), ill64, vt[i].l64);
        end
        in_valid = 1'b0;
        tick();
        check("drain_empty", v32, 1'b0);

        // Backpressure: stream tags 1..4 with out_ready low
        out_ready = 1'b0;
        out_log.delete();
        offer(32'h00100013, 8'd1);
        check("bp_ready_after1", r32, 1'b1);
        check("bp_tag_after1", ot32, 8'd1);
        offer(32'h00200013, 8'd2);
        check("bp_ready_after2", r32, 1'b0);
        check("bp_tag_after2", ot32, 8'd1);
        offer(32'h00300013, 8'd3);
        tick();
        check("bp_ready_hold", r32, 1'b0);
        check("bp_tag_hold", ot32, 8'd1);
        check("bp_instr_hold", oi32, 32'h00100013);
        check("bp_imm_hold", imm32, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic acc;
            check("bp_no_gap", v32, 1'b1);
            acc = in_valid && r32;
            tick();
            if (acc) begin
                if (in_tag == 8'd3) begin
                    in_tag   = 8'd4;
                    in_instr = 32'h00400013;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("bp_out_count", out_log.size(), 4);
        for (int i = 0; i < out_log.size(); i++) check("bp_order", out_log[i], i + 1);
        check("bp_idle", v32, 1'b0);

        // Flush with both entries full while tag 9 is offered
        out_ready = 1'b0;
        offer(32'h00500013, 8'd5);
        offer(32'h00600013, 8'd6);
        check("fl_full", r32, 1'b0);
        in_instr = 32'h00900013;
        in_tag   = 8'd9;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", v32, 1'b0);
        check("fl_in_ready", r32, 1'b1);
        out_ready = 1'b1;
        out_log.delete();
        repeat (3) tick();
        check("fl_no_tag9", out_log.size(), 0);

        // Asynchronous reset between edges with both entries full
        out_ready = 1'b0;
        offer(32'h00700013, 8'd7);
        offer(32'h00800013, 8'd8);
        in_valid = 1'b0;
        check("ar_full", r32, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("ar_out_valid", v32, 1'b0);
        check("ar_in_ready", r32, 1'b1);
        check("ar_imm", imm32, 0);
        check("ar_fmt", fmt32, 0);
        check("ar_illegal", ill32, 0);
        check("ar_instr", oi32, 0);
        check("ar_tag", ot32, 0);
        check("ar_out_valid64", v64, 1'b0);
        #1 reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        tick();

        // Random valid/ready stress with addi encodings
        begin
            int acc_cnt = 0;
            int cyc = 0;
            stim_chk = 1'b1;
            while (acc_cnt < 10000 && cyc < 60000) begin
                logic [11:0] imm12;
                imm12     = 12'($urandom);
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                in_instr  = {imm12, 5'($urandom), 3'b000, 5'($urandom), 7'h13};
                in_tag    = 8'($urandom);
                stim_imm  = {{20{imm12[11]}}, imm12};
                if (in_valid && r32) acc_cnt++;
                tick();
                check("st_inflight", (exp_q.size() <= 2) ? 64'd1 : 64'd0, 64'd1);
                cyc++;
            end
            check("st_beats", (acc_cnt >= 10000) ? 64'd1 : 64'd0, 64'd1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (3) tick();
            check("st_drained", exp_q.size(), 0);
            check("st_idle", v32, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
